// File: rtl/uart_tx_pkg.sv
// Shared definitions for the FIFO-drain UART transmitter: FSM encoding,
// framing constants and counter-width helpers.
package uart_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_e;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int STOP_ONE    = 1;
    localparam int STOP_TWO    = 2;

    // Width needed to count 0..range-1, never narrower than one bit.
    function automatic int cnt_width(input int range);
        return (range > 1) ? $clog2(range) : 1;
    endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts 0..CLK_DIV-1 while enabled and flags the last
// cycle of each line bit.
module uart_baud_cnt
    import uart_tx_pkg::*;
#(
    parameter int CLK_DIV = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int CNT_W = cnt_width(CLK_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt;

    // NOTE: sequential state is updated with non-blocking assignments so every
    // flop samples pre-edge values, independent of process evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
        end
    end

    assign tick = en && (cnt == CNT_LAST);

endmodule

// File: rtl/fifo_uart_tx.sv
// FIFO drain stage: pops one word through the read-allow/empty interface and
// serialises it as start, LSB-first data, optional even parity, stop bit(s).
module fifo_uart_tx
    import uart_tx_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int CLK_DIV   = 16,
    parameter int PARITY_EN = PARITY_NONE,
    parameter int STOP_BITS = STOP_ONE
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              tx_en,
    input  logic              fifo_empty,
    output logic              fifo_rd,
    input  logic [DATA_W-1:0] fifo_rdata,
    output logic              tx,
    output logic              busy,
    output logic              frame_done
);

    localparam int BIT_W = cnt_width(DATA_W + 1);
    localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_W - 1);
    localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);

    tx_state_e         state, state_next;
    logic [DATA_W-1:0] shift_q, shift_next;
    logic [BIT_W-1:0]  bit_cnt, bit_cnt_next;
    logic              parity_q, parity_next;
    logic              tx_q, tx_next;
    logic              done_q, done_next;
    logic              tick;
    logic              baud_clr, baud_en;

    assign fifo_rd  = (state == ST_IDLE) && tx_en && !fifo_empty;
    assign busy     = (state != ST_IDLE);
    assign baud_clr = (state == ST_LOAD);
    assign baud_en  = (state == ST_START) || (state == ST_DATA) ||
                      (state == ST_PARITY) || (state == ST_STOP);

    uart_baud_cnt #(
        .CLK_DIV (CLK_DIV)
    ) u_baud (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (baud_clr),
        .en    (baud_en),
        .tick  (tick)
    );

    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next   = state;
        shift_next   = shift_q;
        bit_cnt_next = bit_cnt;
        parity_next  = parity_q;
        done_next    = 1'b0;

        case (state)
            ST_IDLE: begin
                if (fifo_rd) state_next = ST_LOAD;
            end
            ST_LOAD: begin
                shift_next  = fifo_rdata;
                parity_next = ^fifo_rdata;
                state_next  = ST_START;
            end
            ST_START: begin
                if (tick) state_next = ST_DATA;
            end
            ST_DATA: begin
                if (tick) begin
                    shift_next = shift_q >> 1;
                    if (bit_cnt == DATA_LAST) begin
                        bit_cnt_next = '0;
                        state_next   = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_cnt_next = bit_cnt + 1'b1;
                    end
                end
            end
            ST_PARITY: begin
                if (tick) state_next = ST_STOP;
            end
            ST_STOP: begin
                if (tick) begin
                    if (bit_cnt == STOP_LAST) begin
                        bit_cnt_next = '0;
                        state_next   = ST_IDLE;
                        done_next    = 1'b1;
                    end else begin
                        bit_cnt_next = bit_cnt + 1'b1;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase

        // The line register follows the state being entered, so tx lines up
        // with the state it belongs to.
        case (state_next)
            ST_START:  tx_next = 1'b0;
            ST_DATA:   tx_next = shift_next[0];
            ST_PARITY: tx_next = parity_q;
            default:   tx_next = 1'b1;
        endcase
    end

    // NOTE: the shift register is reset like the control state; it is small and
    // a known value keeps the line deterministic after any reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            shift_q  <= '0;
            bit_cnt  <= '0;
            parity_q <= 1'b0;
            tx_q     <= 1'b1;
            done_q   <= 1'b0;
        end else begin
            state    <= state_next;
            shift_q  <= shift_next;
            bit_cnt  <= bit_cnt_next;
            parity_q <= parity_next;
            tx_q     <= tx_next;
            done_q   <= done_next;
        end
    end

    assign tx         = tx_q;
    assign frame_done = done_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx: one 8N1 instance and one 8E2 instance,
// each fed by a small behavioural FIFO.
module tb_fifo_uart_tx;
    import uart_tx_pkg::*;

    localparam int CLK_DIV = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    // 8N1 instance
    logic       tx_en = 1'b0;
    logic       fifo_empty, fifo_rd, tx, busy, frame_done;
    logic [7:0] fifo_rdata = '0;
    logic [7:0] mem_a [16];
    logic [3:0] wr_a = '0;
    logic [3:0] rd_a = '0;

    // 8E2 instance
    logic       tx_en1 = 1'b0;
    logic       fifo_empty1, fifo_rd1, tx1, busy1, frame_done1;
    logic [7:0] fifo_rdata1 = '0;
    logic [7:0] mem_b [16];
    logic [3:0] wr_b = '0;
    logic [3:0] rd_b = '0;

    int checks   = 0;
    int failures = 0;

    logic [255:0] samp_tx, samp_rd, samp_done, samp_busy, samp_tx1, samp_done1;

    always #5 clk = ~clk;

    fifo_uart_tx #(
        .DATA_W(8), .CLK_DIV(CLK_DIV), .PARITY_EN(PARITY_NONE), .STOP_BITS(STOP_ONE)
    ) dut (
        .clk(clk), .rst_n(rst_n), .tx_en(tx_en), .fifo_empty(fifo_empty),
        .fifo_rd(fifo_rd), .fifo_rdata(fifo_rdata), .tx(tx), .busy(busy),
        .frame_done(frame_done)
    );

    fifo_uart_tx #(
        .DATA_W(8), .CLK_DIV(CLK_DIV), .PARITY_EN(PARITY_EVEN), .STOP_BITS(STOP_TWO)
    ) dut_par (
        .clk(clk), .rst_n(rst_n), .tx_en(tx_en1), .fifo_empty(fifo_empty1),
        .fifo_rd(fifo_rd1), .fifo_rdata(fifo_rdata1), .tx(tx1), .busy(busy1),
        .frame_done(frame_done1)
    );

    assign fifo_empty  = (wr_a == rd_a);
    assign fifo_empty1 = (wr_b == rd_b);

    // Read data appears the cycle after the read request.
    always @(posedge clk) begin
        if (fifo_rd) begin
            fifo_rdata <= mem_a[rd_a];
            rd_a       <= rd_a + 4'd1;
        end
        if (fifo_rd1) begin
            fifo_rdata1 <= mem_b[rd_b];
            rd_b        <= rd_b + 4'd1;
        end
    end

    task automatic push_a(input logic [7:0] d);
        mem_a[wr_a] = d;
        wr_a = wr_a + 4'd1;
    endtask

    task automatic push_b(input logic [7:0] d);
        mem_b[wr_b] = d;
        wr_b = wr_b + 4'd1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Samples outputs at n consecutive falling edges into slots from..from+n-1.
    task automatic record(input int from, input int n);
        if (from == 0) begin
            samp_tx = '0; samp_rd = '0; samp_done = '0; samp_busy = '0;
            samp_tx1 = '0; samp_done1 = '0;
        end
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            samp_tx[from+i]    = tx;
            samp_rd[from+i]    = fifo_rd;
            samp_done[from+i]  = frame_done;
            samp_busy[from+i]  = busy;
            samp_tx1[from+i]   = tx1;
            samp_done1[from+i] = frame_done1;
        end
    endtask

    function automatic logic [255:0] mask(input int n);
        return (256'(1) << n) - 256'(1);
    endfunction

    function automatic logic [63:0] slice(input logic [255:0] v, input int from, input int n);
        return 64'((v >> from) & mask(n));
    endfunction

    function automatic logic [63:0] ones(input logic [255:0] v, input int from, input int n);
        return 64'($countones((v >> from) & mask(n)));
    endfunction

    // Each line bit of a hand-written frame pattern held for CLK_DIV samples.
    function automatic logic [63:0] expand(input logic [15:0] pat, input int nbits);
        logic [63:0] r = '0;
        for (int b = 0; b < nbits; b++)
            for (int k = 0; k < CLK_DIV; k++)
                r[b*CLK_DIV+k] = pat[b];
        return r;
    endfunction

    initial begin
        // Reset state
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_tx", 64'(tx), 64'd1);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(frame_done), 64'd0);
        check("reset_rd", 64'(fifo_rd), 64'd0);

        // Single word 0xA5: slot 0 is LOAD, slots 1..40 the frame, slot 41 IDLE
        push_a(8'hA5);
        tx_en = 1'b1;
        #1;
        check("single_rd_now", 64'(fifo_rd), 64'd1);
        record(0, 43);
        check("single_load_tx", 64'(samp_tx[0]), 64'd1);
        check("single_line", slice(samp_tx, 1, 40), expand(16'b1101001010, 10));
        check("single_rd_count", ones(samp_rd, 0, 43), 64'd0);
        check("single_done_count", ones(samp_done, 0, 43), 64'd1);
        check("single_done_slot", 64'(samp_done[41]), 64'd1);
        check("single_busy_last", 64'(samp_busy[40]), 64'd1);
        check("single_busy_fall", 64'(samp_busy[41]), 64'd0);

        // Back-to-back 0x01, 0xFF: second pop at slot 41 (42 cycles after first)
        tx_en = 1'b0;
        push_a(8'h01);
        push_a(8'hFF);
        tx_en = 1'b1;
        #1;
        check("b2b_rd_now", 64'(fifo_rd), 64'd1);
        record(0, 90);
        check("b2b_line1", slice(samp_tx, 1, 40), expand(16'b1000000010, 10));
        check("b2b_rd_count", ones(samp_rd, 0, 90), 64'd1);
        check("b2b_rd_slot", 64'(samp_rd[41]), 64'd1);
        check("b2b_gap", slice(samp_tx, 41, 2), 64'b11);
        check("b2b_start2", 64'(samp_tx[43]), 64'd0);
        check("b2b_line2", slice(samp_tx, 43, 40), expand(16'b1111111110, 10));
        check("b2b_done_count", ones(samp_done, 0, 90), 64'd2);

        // Even parity, two stop bits, word 0x07: parity bit 1, 48-cycle frame
        push_b(8'h07);
        tx_en1 = 1'b1;
        #1;
        check("par_rd_now", 64'(fifo_rd1), 64'd1);
        record(0, 52);
        check("par_line", slice(samp_tx1, 1, 48), expand(16'b111000001110, 12));
        check("par_bit", slice(samp_tx1, 37, 4), 64'hF);
        check("par_stop_high", ones(samp_tx1, 41, 8), 64'd8);
        check("par_done_early", 64'(samp_done1[48]), 64'd0);
        check("par_done_slot", 64'(samp_done1[49]), 64'd1);
        // 8N1 instance idle with an empty FIFO throughout
        check("empty_rd", ones(samp_rd, 0, 52), 64'd0);
        check("empty_tx", ones(samp_tx, 0, 52), 64'd52);
        tx_en1 = 1'b0;

        // Flow control: drop tx_en in the middle of line bit 3 of 0x3C
        push_a(8'h3C);
        push_a(8'h5A);
        #1;
        check("flow_rd_now", 64'(fifo_rd), 64'd1);
        record(0, 15);
        tx_en = 1'b0;
        record(15, 60);
        check("flow_line", slice(samp_tx, 1, 40), expand(16'b1001111000, 10));
        check("flow_rd_none", ones(samp_rd, 0, 75), 64'd0);
        check("flow_idle_high", ones(samp_tx, 41, 34), 64'd34);
        check("flow_done_count", ones(samp_done, 0, 75), 64'd1);
        tx_en = 1'b1;
        #1;
        check("flow_resume_rd", 64'(fifo_rd), 64'd1);
        record(0, 42);
        check("flow_line2", slice(samp_tx, 1, 40), expand(16'b1010110100, 10));

        // Reset in the middle of a 0x00 frame's data bits
        push_a(8'h00);
        #1;
        check("rst_rd_now", 64'(fifo_rd), 64'd1);
        record(0, 21);
        check("rst_line_low", 64'(samp_tx[20]), 64'd0);
        check("rst_busy_before", 64'(samp_busy[20]), 64'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_tx_async", 64'(tx), 64'd1);
        check("rst_busy_async", 64'(busy), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        record(0, 50);
        check("post_rst_rd", ones(samp_rd, 0, 50), 64'd0);
        check("post_rst_tx", ones(samp_tx, 0, 50), 64'd50);
        check("post_rst_busy", ones(samp_busy, 0, 50), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
